// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ==========================================================================
// riscv_decode_stage : RV32I(+M) decoder feeding a registered output FIFO
// Rev 1.0
// ==========================================================================
module riscv_decode_stage #(
  parameter int PC_W     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_instr_i,
  input  logic [PC_W-1:0]        in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PC_W-1:0]        out_pc_o,
  output logic [31:0]            out_imm_o,
  output logic [4:0]             out_rd_o,
  output logic [4:0]             out_ra_o,
  output logic [4:0]             out_rb_o,
  output logic [3:0]             out_alu_op_o,
  output logic                   out_branch_o,
  output logic [2:0]             out_br_cond_o,
  output logic [1:0]             out_mem_size_o,
  output logic                   out_load_o,
  output logic                   out_store_o,
  output logic                   out_unsigned_o,
  output logic                   out_jal_o,
  output logic                   out_jalr_o,
  output logic                   out_alu_imm_o,
  output logic                   out_muldiv_o,
  output logic                   out_illegal_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [3:0]      alu_op;
    logic            branch;
    logic [2:0]      br_cond;
    logic [1:0]      mem_size;
    logic            load;
    logic            store;
    logic            uns;
    logic            jal;
    logic            jalr;
    logic            alu_imm;
    logic            muldiv;
    logic            illegal;
  } bundle_t;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_bad;
  bundle_t         w_dec;

  assign w_opc = in_instr_i[6:0];
  assign w_f3  = in_instr_i[14:12];
  assign w_f7  = in_instr_i[31:25];

  always_comb begin
    w_dec         = '0;
    w_bad         = 1'b0;
    w_dec.pc      = in_pc_i;
    w_dec.rd      = in_instr_i[11:7];
    w_dec.ra      = in_instr_i[19:15];
    w_dec.rb      = in_instr_i[24:20];
    w_dec.imm     = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    case (w_opc)
      c_OPC_LUI, c_OPC_AUIPC: begin
        w_dec.imm     = {in_instr_i[31:12], 12'h000};
        w_dec.alu_imm = 1'b1;
      end
      c_OPC_JAL: begin
        w_dec.imm = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                     in_instr_i[20], in_instr_i[30:21], 1'b0};
        w_dec.jal = 1'b1;
      end
      c_OPC_JALR: begin
        w_dec.jalr    = 1'b1;
        w_dec.alu_imm = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_dec.imm     = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                         in_instr_i[30:25], in_instr_i[11:8], 1'b0};
        w_dec.branch  = 1'b1;
        w_dec.br_cond = w_f3;
        w_bad         = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      c_OPC_LOAD: begin
        w_dec.load     = 1'b1;
        w_dec.alu_imm  = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.uns      = w_f3[2];
        w_bad          = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_OPC_STORE: begin
        w_dec.imm      = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
        w_dec.store    = 1'b1;
        w_dec.alu_imm  = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.uns      = w_f3[2];
        w_bad          = (w_f3 > 3'b010);
      end
      c_OPC_OPIMM: begin
        w_dec.alu_imm = 1'b1;
        if (w_f3 == 3'b001) begin
          w_dec.alu_op = {in_instr_i[30], w_f3};
          w_bad        = (w_f7 != 7'h00);
        end else if (w_f3 == 3'b101) begin
          w_dec.alu_op = {in_instr_i[30], w_f3};
          w_bad        = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        end else begin
          w_dec.alu_op = {1'b0, w_f3};
        end
      end
      c_OPC_OP: begin
        w_dec.imm    = '0;
        w_dec.alu_op = {in_instr_i[30], w_f3};
        case (w_f7)
          7'h00:   w_bad = 1'b0;
          7'h20:   w_bad = (w_f3 != 3'b000) && (w_f3 != 3'b101);
          7'h01: begin
            w_dec.muldiv = ENABLE_M;
            w_bad        = !ENABLE_M;
          end
          default: w_bad = 1'b1;
        endcase
      end
      c_OPC_FENCE, c_OPC_SYSTEM: w_bad = 1'b0;
      default: begin
        w_dec.imm = '0;
        w_bad     = 1'b1;
      end
    endcase
    w_dec.illegal = w_bad || (in_instr_i[1:0] != 2'b11) || (in_instr_i == 32'd0);
  end

  bundle_t         r_mem [DEPTH];
  bundle_t         r_head;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic            w_out_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_in_ready;
  logic            w_head_from_in;
  logic [c_AW-1:0] w_rd_ptr_nxt;
  logic [c_CW-1:0] w_count_nxt;
  bundle_t         w_head_nxt;

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & out_ready_i;
  assign w_in_ready  = flush_i | (r_count != c_FULL) | w_pop;
  assign w_push      = in_valid_i & w_in_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CW'(1);
      2'b01:   w_count_nxt = r_count - c_CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // The head register tracks the next head: the incoming bundle when the FIFO drains to it, else storage.
  assign w_rd_ptr_nxt   = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;
  assign w_head_from_in = w_push & (r_count == c_CW'(w_pop));
  assign w_head_nxt     = w_head_from_in ? w_dec : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= w_dec;
  end

  assign in_ready_o     = w_in_ready;
  assign out_valid_o    = w_out_valid;
  assign count_o        = r_count;
  assign out_pc_o       = r_head.pc;
  assign out_imm_o      = r_head.imm;
  assign out_rd_o       = r_head.rd;
  assign out_ra_o       = r_head.ra;
  assign out_rb_o       = r_head.rb;
  assign out_alu_op_o   = r_head.alu_op;
  assign out_branch_o   = r_head.branch;
  assign out_br_cond_o  = r_head.br_cond;
  assign out_mem_size_o = r_head.mem_size;
  assign out_load_o     = r_head.load;
  assign out_store_o    = r_head.store;
  assign out_unsigned_o = r_head.uns;
  assign out_jal_o      = r_head.jal;
  assign out_jalr_o     = r_head.jalr;
  assign out_alu_imm_o  = r_head.alu_imm;
  assign out_muldiv_o   = r_head.muldiv;
  assign out_illegal_o  = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// Bench for riscv_decode_stage: directed vector table, hand sequences and a
// randomized run against a queue-based reference model (M enabled and disabled).
module tb_riscv_decode_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [3:0]  alu_op;
    logic        branch;
    logic [2:0]  br_cond;
    logic [1:0]  mem_size;
    logic        load;
    logic        store;
    logic        uns;
    logic        jal;
    logic        jalr;
    logic        alu_imm;
    logic        muldiv;
    logic        illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] imm;
    logic        alu_imm;
    logic        branch;
    logic [2:0]  br_cond;
    logic        muldiv;
    logic        ill_m;
    logic        ill_nom;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush_i, in_valid_i, out_ready_i;
  logic [31:0] in_instr_i, in_pc_i;

  logic in_ready_o, out_valid_o, out_branch_o, out_load_o, out_store_o, out_unsigned_o;
  logic out_jal_o, out_jalr_o, out_alu_imm_o, out_muldiv_o, out_illegal_o;
  logic [31:0] out_pc_o, out_imm_o;
  logic [4:0] out_rd_o, out_ra_o, out_rb_o;
  logic [3:0] out_alu_op_o;
  logic [2:0] out_br_cond_o;
  logic [1:0] out_mem_size_o, count_o;

  logic n_in_ready, n_valid, n_branch, n_load, n_store, n_uns, n_jal, n_jalr, n_alu_imm, n_muldiv, n_illegal;
  logic [31:0] n_pc, n_imm;
  logic [4:0] n_rd, n_ra, n_rb;
  logic [3:0] n_alu_op;
  logic [2:0] n_br_cond;
  logic [1:0] n_mem_size, n_count;

  always #5 clk = ~clk;

  riscv_decode_stage #(.PC_W(32), .ENABLE_M(1'b1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_imm_o(out_imm_o), .out_rd_o(out_rd_o), .out_ra_o(out_ra_o),
    .out_rb_o(out_rb_o), .out_alu_op_o(out_alu_op_o), .out_branch_o(out_branch_o),
    .out_br_cond_o(out_br_cond_o), .out_mem_size_o(out_mem_size_o), .out_load_o(out_load_o),
    .out_store_o(out_store_o), .out_unsigned_o(out_unsigned_o), .out_jal_o(out_jal_o),
    .out_jalr_o(out_jalr_o), .out_alu_imm_o(out_alu_imm_o), .out_muldiv_o(out_muldiv_o),
    .out_illegal_o(out_illegal_o), .count_o(count_o));

  riscv_decode_stage #(.PC_W(32), .ENABLE_M(1'b0), .DEPTH(DEPTH)) dut_nom (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(n_in_ready),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i), .out_valid_o(n_valid), .out_ready_i(out_ready_i),
    .out_pc_o(n_pc), .out_imm_o(n_imm), .out_rd_o(n_rd), .out_ra_o(n_ra), .out_rb_o(n_rb),
    .out_alu_op_o(n_alu_op), .out_branch_o(n_branch), .out_br_cond_o(n_br_cond),
    .out_mem_size_o(n_mem_size), .out_load_o(n_load), .out_store_o(n_store),
    .out_unsigned_o(n_uns), .out_jal_o(n_jal), .out_jalr_o(n_jalr), .out_alu_imm_o(n_alu_imm),
    .out_muldiv_o(n_muldiv), .out_illegal_o(n_illegal), .count_o(n_count));

  bundle_t act_m, act_n, m_last, m_last_n;
  assign act_m = {out_pc_o, out_imm_o, out_rd_o, out_ra_o, out_rb_o, out_alu_op_o, out_branch_o,
                  out_br_cond_o, out_mem_size_o, out_load_o, out_store_o, out_unsigned_o,
                  out_jal_o, out_jalr_o, out_alu_imm_o, out_muldiv_o, out_illegal_o};
  assign act_n = {n_pc, n_imm, n_rd, n_ra, n_rb, n_alu_op, n_branch, n_br_cond, n_mem_size,
                  n_load, n_store, n_uns, n_jal, n_jalr, n_alu_imm, n_muldiv, n_illegal};

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] q[$];
  logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input int v, input int bits);
    int r;
    r = v;
    if (v >= (1 << (bits - 1))) r = v - (1 << bits);
    return 32'(r);
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] pc, input logic [31:0] ins, input bit en_m);
    bundle_t b;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    logic [31:0] imm_i;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    imm_i = sext(int'(ins[31:20]), 12);
    b = '0; ok = 1;
    b.pc = pc; b.rd = ins[11:7]; b.ra = ins[19:15]; b.rb = ins[24:20];
    case (opc)
      7'h37, 7'h17: begin b.imm = 32'(ins[31:12]) << 12; b.alu_imm = 1; end
      7'h6f: begin
        b.imm = sext(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                     int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
        b.jal = 1;
      end
      7'h67: begin b.imm = imm_i; b.jalr = 1; b.alu_imm = 1; end
      7'h63: begin
        b.imm = sext(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                     int'(ins[11:8]) * 2, 13);
        b.branch = 1; b.br_cond = f3; ok = !(f3 inside {3'd2, 3'd3});
      end
      7'h03: begin
        b.imm = imm_i; b.load = 1; b.alu_imm = 1; b.mem_size = f3[1:0]; b.uns = f3[2];
        ok = !(f3 inside {3'd3, 3'd6, 3'd7});
      end
      7'h23: begin
        b.imm = sext(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
        b.store = 1; b.alu_imm = 1; b.mem_size = f3[1:0]; b.uns = f3[2]; ok = (f3 <= 3'd2);
      end
      7'h13: begin
        b.imm = imm_i; b.alu_imm = 1;
        if (f3 == 3'd1) begin b.alu_op = {ins[30], f3}; ok = (f7 == 7'h00); end
        else if (f3 == 3'd5) begin b.alu_op = {ins[30], f3}; ok = (f7 inside {7'h00, 7'h20}); end
        else b.alu_op = {1'b0, f3};
      end
      7'h33: begin
        b.alu_op = {ins[30], f3};
        if (f7 == 7'h00) ok = 1;
        else if (f7 == 7'h20) ok = (f3 inside {3'd0, 3'd5});
        else if (f7 == 7'h01) begin ok = en_m; b.muldiv = en_m; end
        else ok = 0;
      end
      7'h0f, 7'h73: b.imm = imm_i;
      default: ok = 0;
    endcase
    b.illegal = !ok || (ins[1:0] != 2'b11) || (ins == 32'd0);
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    int sel;
    x = $urandom();
    sel = $urandom_range(0, 7);
    if (sel == 0) return x;
    if (sel == 1) return 32'd0;
    x[6:0] = opcs[$urandom_range(0, 10)];
    sel = $urandom_range(0, 3);
    if (sel == 0) x[31:25] = 7'h00;
    else if (sel == 1) x[31:25] = 7'h20;
    else if (sel == 2) x[31:25] = 7'h01;
    return x;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid_o, q.size() != 0);
    chk("count", count_o, q.size());
    chk("payload_m", act_m, m_last);
    chk("nom_valid", n_valid, q.size() != 0);
    chk("payload_nom", act_n, m_last_n);
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit pop, rdy, push;
    @(negedge clk);
    in_valid_i = v; in_instr_i = ins; in_pc_i = pc; out_ready_i = ordy; flush_i = fl;
    #1;
    pop  = (q.size() != 0) && ordy;
    rdy  = fl || (q.size() != DEPTH) || pop;
    push = v && rdy;
    chk("in_ready", in_ready_o, rdy);
    chk("nom_in_ready", n_in_ready, rdy);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({pc, ins});
    end
    if (q.size() != 0) begin
      m_last   = ref_decode(q[0][63:32], q[0][31:0], 1'b1);
      m_last_n = ref_decode(q[0][63:32], q[0][31:0], 1'b0);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_instr_i = '0; in_pc_i = '0;
    m_last = '0; m_last_n = '0;
    vecs[0] = '{32'h00000293, 5'd5,  5'd0,  5'd0,  32'd0,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00a00393, 5'd7,  5'd0,  5'd10, 32'd10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0072d463, 5'd8,  5'd5,  5'd7,  32'd8,  1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h00128293, 5'd5,  5'd5,  5'd1,  32'd1,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h02b50533, 5'd10, 5'd10, 5'd11, 32'd0,  1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h00000000, 5'd0,  5'd0,  5'd0,  32'd0,  1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{32'hffffffff, 5'd31, 5'd31, 5'd31, 32'd0,  1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_in_ready", in_ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, vecs[k].instr, 32'h1000 + 32'(4 * k), 1'b1, 1'b0);
      chk("vec_valid", out_valid_o, 1'b1);
      chk("vec_pc", out_pc_o, 32'h1000 + 32'(4 * k));
      chk("vec_rd", out_rd_o, vecs[k].rd);
      chk("vec_ra", out_ra_o, vecs[k].ra);
      chk("vec_rb", out_rb_o, vecs[k].rb);
      chk("vec_imm", out_imm_o, vecs[k].imm);
      chk("vec_alu_imm", out_alu_imm_o, vecs[k].alu_imm);
      chk("vec_branch", out_branch_o, vecs[k].branch);
      chk("vec_br_cond", out_br_cond_o, vecs[k].br_cond);
      chk("vec_muldiv", out_muldiv_o, vecs[k].muldiv);
      chk("vec_illegal_m", out_illegal_o, vecs[k].ill_m);
      chk("vec_illegal_nom", n_illegal, vecs[k].ill_nom);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Backpressure: two entries fill the FIFO, the third waits for a pop
    cycle(1'b1, 32'h00100093, 32'h2000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h2004, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h2008, 1'b0, 1'b0);
    chk("bp_count_full", count_o, 2'd2);
    chk("bp_ready_low", in_ready_o, 1'b0);
    chk("bp_head_first", out_pc_o, 32'h2000);
    cycle(1'b1, 32'h00300193, 32'h2008, 1'b1, 1'b0);
    chk("bp_count_pushpop", count_o, 2'd2);
    chk("bp_head_second", out_pc_o, 32'h2004);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_head_third", out_pc_o, 32'h2008);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_drained_hold", out_pc_o, 32'h2008);

    // Flush with two entries and a concurrent push
    cycle(1'b1, 32'h00400213, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500293, 32'h3004, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 32'h3008, 1'b1, 1'b1);
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_count", count_o, 2'd0);
    cycle(1'b1, 32'h00700393, 32'h300c, 1'b0, 1'b0);
    chk("post_flush_pc", out_pc_o, 32'h300c);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    cycle(1'b1, 32'h00800413, 32'h4000, 1'b0, 1'b0);
    #2;
    in_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 1'b0);
    chk("async_rst_count", count_o, 2'd0);
    chk("async_rst_pc", out_pc_o, 32'd0);
    chk("async_rst_imm", out_imm_o, 32'd0);
    q.delete();
    m_last = '0; m_last_n = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Registered, parametrised successor to the combinational RV32 decoder.
- Accepts fetched instructions with their PC over a valid/ready handshake and decodes them (RV32I, plus optional M extension).
- Buffers decoded bundles in an output FIFO of configurable depth, with backpressure and flush.
- Sits between the fetch unit and issue/execute. Illegal instructions pass through with a flag; they are never dropped.

Parameters:
- PC_W, 32, PC width carried alongside each instruction.
- ENABLE_M, 1, 1 = decode MUL/DIV/REM (funct7=0x01); 0 = flag them illegal.
- DEPTH, 2, output FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- in_valid_i  in  1  instruction/PC valid.
- in_ready_o  out  1  stage can accept this cycle.
- in_instr_i  in  32  raw instruction.
- in_pc_i  in  PC_W  PC of instruction.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes head entry.
- out_pc_o  out  PC_W  PC of head entry.
- out_imm_o  out  32  sign-extended immediate (I/S/B/U/J format).
- out_rd_o, out_ra_o, out_rb_o  out  5 each  register indices.
- out_alu_op_o  out  4  ALU op.
- out_branch_o  out  1  conditional branch.
- out_br_cond_o  out  3  branch funct3.
- out_mem_size_o  out  2  funct3[1:0] for loads/stores.
- out_load_o, out_store_o, out_unsigned_o, out_jal_o, out_jalr_o, out_alu_imm_o, out_muldiv_o, out_illegal_o  out  1 each  decode flags.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO pointers and count go to 0; out_valid_o=0.
  - All out_* payload outputs are 0; in_ready_o=1 once rst deasserts.
- Handshakes:
  - Accept when in_valid_i & in_ready_o.
  - Pop when out_valid_o & out_ready_i.
  - in_ready_o = (count_o != DEPTH) | pop. This allows simultaneous push/pop when full; the count is unchanged.
- Latency: an instruction accepted at edge N is visible on out_* after edge N with out_valid_o=1. That is 1 cycle into an empty FIFO; otherwise it follows FIFO order.
- Head outputs come from a register/array read. When out_valid_o=0 the payload is held at its last value (0 after reset).
- Decode is combinational on in_instr_i and is written into the FIFO at the accept edge.
- Decode rules:
  - rd=[11:7], ra=[19:15], rb=[24:20] are always extracted.
  - alu_op = {instr[30], funct3} for OP and for OP-IMM shifts.
  - alu_op = {0, funct3} for other OP-IMM.
  - alu_op = 0000 (ADD) for everything else.
  - alu_imm=1 for OP-IMM, LOAD, STORE, JALR, AUIPC, LUI.
  - branch/br_cond apply to BRANCH only. load/store/unsigned/mem_size apply to LOAD/STORE only; unsigned = funct3[2].
  - muldiv=1 for OP with funct7=0x01 when ENABLE_M=1.
- Illegal conditions:
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM}.
  - instr[1:0] != 11.
  - OP funct7 not in {0x00, 0x20 (funct3 000/101 only), 0x01 (only if ENABLE_M)}.
  - BRANCH funct3 010/011.
  - LOAD funct3 011/110/111; STORE funct3 > 010.
  - Shift-immediate with bad funct7.
  - All-zero instruction.
- Illegal entries keep their other fields as decoded and have out_illegal_o=1.
- flush_i=1 at edge:
  - count and pointers go to 0 and out_valid_o=0 next cycle.
  - Any same-cycle accept or pop is discarded.
  - in_ready_o is still asserted that cycle.
- Empty FIFO, push with out_ready_i=1: entry appears next cycle. There is no combinational bypass.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset mid-stream: fill 1 entry, assert rst=0 asynchronously -> out_valid_o=0, count_o=0 immediately, without waiting for a clock edge.
- Stream 0x00000293, 0x00a00393, 0x0072d463, 0x00128293 with out_ready_i=1 -> in this order:
  - 0x00000293: rd=5, ra=0, imm=0, alu_imm=1.
  - 0x00a00393: rd=7, imm=10.
  - 0x0072d463: branch=1, br_cond=101, ra=5, rb=7, imm=8.
  - 0x00128293: rd=5, ra=5, imm=1.
  - Each appears 1 cycle after its accept.
- Backpressure, DEPTH=2, out_ready_i=0: push 3 instructions -> count_o=2, in_ready_o=0, third held. Raise out_ready_i -> simultaneous push/pop, count stays 2, order preserved.
- 0x02b50533 (mul x10,x10,x11) -> ENABLE_M=1: muldiv=1, illegal=0; ENABLE_M=0: illegal=1.
- 0x00000000 and 0xffffffff -> illegal=1, entry still delivered.
- Flush with 2 entries plus a concurrent push -> next cycle out_valid_o=0, count_o=0; a push the following cycle emerges normally.
